aes_result_checker: RTL and testbench
=====================================

Name: aes_result_checker

Overview:
- Result-side companion to the AES-128 stimulus driver.
- Watches the cipher core's `ld`/`done`/`text_out` handshake on `sys_clk` and captures each ciphertext on `done`.
- Compares the capture against a known-answer constant and keeps saturating pass/fail/timeout/spurious statistics.
- Drives a single on-board status LED. Sits in the top level beside the cipher core; it is an observer only and never drives the core.

Parameters:
- EXPECTED, 128'h3ad77bb40d7a3660a89ecaf32466ef97, known-answer ciphertext (SP800-38A ECB block 1).
- TIMEOUT_CYCLES, 64, max cycles from `ld` to `done` before a timeout is declared.
- CNT_W, 16, width of each statistics counter.

Ports:
- sys_clk  input  1  50 MHz system clock.
- sys_rst_n  input  1  asynchronous active-low reset.
- ld  input  1  load strobe the driver sends to the cipher core.
- done  input  1  cipher core completion pulse; one cycle; `text_out` is valid in that cycle.
- text_out  input  128  cipher core result.
- busy  output  1  high while awaiting `done`.
- match  output  1  one-cycle pulse: last result equalled EXPECTED.
- mismatch  output  1  one-cycle pulse: last result differed.
- err_sticky  output  1  set on any mismatch, timeout or spurious `done`; cleared only by reset.
- pass_cnt  output  CNT_W  matching results.
- fail_cnt  output  CNT_W  mismatching results.
- timeout_cnt  output  CNT_W  timeouts.
- spurious_cnt  output  CNT_W  `done` seen while IDLE, plus `ld` re-issued while WAIT.
- last_result  output  128  most recent captured `text_out`.
- status_led  output  1  high when pass_cnt != 0 and err_sticky == 0.

Behaviour:
- Reset, asynchronous, active-low: state IDLE; all outputs 0; timer 0. `last_result` resets to 0.
- States: IDLE, WAIT, CHECK.
- IDLE:
  - `ld`=1 -> WAIT, timer cleared, busy=1 from the next cycle.
  - `done`=1 (with or without `ld`) -> spurious_cnt+1, err_sticky=1, `text_out` ignored.
  - If `done` and `ld` arrive together: count the spurious event and also go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - `done`=1 -> capture `text_out` into `last_result` and an internal compare register -> CHECK.
  - `done` takes priority over `ld` and over timeout in the same cycle.
  - `ld`=1 without `done` -> spurious_cnt+1, err_sticky=1, timer restarts at 0, stay in WAIT.
  - Timer reaches TIMEOUT_CYCLES-1 with no `done` -> timeout_cnt+1, err_sticky=1 -> IDLE.
- CHECK (exactly one cycle):
  - Registered 128-bit equality against EXPECTED.
  - Equal: match=1 for one cycle, pass_cnt+1.
  - Not equal: mismatch=1 for one cycle, fail_cnt+1, err_sticky=1.
  - -> IDLE; busy=0 from the next cycle.
  - `ld` arriving in CHECK is honoured: next state WAIT instead of IDLE.
  - `done` arriving in CHECK is counted as spurious.
- Latency: `done` cycle N -> match/mismatch and counter update visible at N+2 (capture at N+1, compare result registered at N+2).
- Counters saturate at 2^CNT_W-1; no wrap.
- Timer width is clog2(TIMEOUT_CYCLES)+1 bits.
- match and mismatch are never both high.
- Reset mid-WAIT or mid-CHECK: everything returns to reset values immediately; no partial counter update.
- `status_led` is registered.

Decomposition:
- Shared package `aes_tb_pkg`:
  - AES_KAT_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c
  - AES_KAT_PLAIN = 128'h6bc1bee22e409f96e93d7e117393172a
  - AES_KAT_CIPHER = 128'h3ad77bb40d7a3660a89ecaf32466ef97
  - state encoding constants IDLE=2'd0, WAIT=2'd1, CHECK=2'd2
- One sub-module: `sat_counter` (parameter W; ports inc, sys_clk, sys_rst_n, q), instantiated four times.

Test Plan:
- Reset, then `ld` pulse; 12 cycles later `done` with `text_out`=AES_KAT_CIPHER -> match pulse 2 cycles after `done`, pass_cnt=1, busy falls, status_led=1, err_sticky=0.
- Same sequence but `text_out`=AES_KAT_CIPHER^128'h1 -> mismatch pulse, fail_cnt=1, err_sticky=1, status_led=0; last_result=...ef96.
- `ld`, then no `done` for 64 cycles -> timeout_cnt=1, busy=0 at cycle 64, err_sticky=1; a later correct `done` in IDLE -> spurious_cnt=1, pass_cnt unchanged.
- `done` and timer expiry in the same cycle; then `ld` during CHECK -> result counted (pass_cnt+1, timeout_cnt 0); state WAIT next cycle, busy stays 1.
- Force pass_cnt to 16'hFFFE and issue 3 good transactions -> pass_cnt holds at 16'hFFFF.
- Assert sys_rst_n=0 asynchronously one cycle after `done` -> all counters, busy, match, err_sticky are 0 before the next clock edge; no match pulse follows release.

Source files
------------

// File: rtl/aes_tb_pkg.sv
// -----------------------------------------------------------------------------
// aes_tb_pkg
// Shared constants for the AES-128 known-answer test harness: the SP800-38A
// ECB block 1 key/plaintext/ciphertext triple and the result-checker state
// encoding.
// -----------------------------------------------------------------------------
package aes_tb_pkg;

    localparam logic [127:0] AES_KAT_KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] AES_KAT_PLAIN  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] AES_KAT_CIPHER = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2
    } chk_state_t;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   sys_clk   - clock
//   sys_rst_n - asynchronous active-low reset, clears the count
//   inc       - add one this cycle (ignored once saturated)
//   q         - current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/aes_result_checker.sv
// -----------------------------------------------------------------------------
// aes_result_checker
// Passive observer beside the AES-128 core. Tracks the ld/done handshake,
// captures each ciphertext, compares it against a known answer and keeps
// saturating pass/fail/timeout/spurious statistics plus a status LED.
// Ports:
//   sys_clk, sys_rst_n   - clock, asynchronous active-low reset
//   ld, done, text_out   - observed core handshake and result
//   busy                 - a result is outstanding (WAIT or CHECK)
//   match / mismatch     - one-cycle verdict pulses, two cycles after done
//   err_sticky           - any mismatch, timeout or spurious event since reset
//   pass_cnt, fail_cnt, timeout_cnt, spurious_cnt - saturating statistics
//   last_result          - most recent captured text_out
//   status_led           - registered: at least one pass and no error
// -----------------------------------------------------------------------------
module aes_result_checker
    import aes_tb_pkg::*;
#(
    parameter logic [127:0] EXPECTED       = AES_KAT_CIPHER,
    parameter int           TIMEOUT_CYCLES = 64,
    parameter int           CNT_W          = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             ld,
    input  logic             done,
    input  logic [127:0]     text_out,
    output logic             busy,
    output logic             match,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [CNT_W-1:0] spurious_cnt,
    output logic [127:0]     last_result,
    output logic             status_led
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    chk_state_t       r_state;
    chk_state_t       w_next;
    logic [TMR_W-1:0] r_timer;
    logic [127:0]     r_cmp;
    logic [127:0]     r_last;
    logic             r_match;
    logic             r_mismatch;
    logic             r_err;
    logic             r_led;

    logic             w_capture;
    logic             w_tmr_clr;
    logic             w_spur;
    logic             w_tmo;
    logic             w_eq;
    logic             w_pass_inc;
    logic             w_fail_inc;
    logic [CNT_W-1:0] w_pass_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_tmr_clr = 1'b0;
        w_spur    = 1'b0;
        w_tmo     = 1'b0;
        case (r_state)
            IDLE: begin
                // A done here has no outstanding request; its data is dropped.
                w_spur = done;
                if (ld) begin
                    w_next    = WAIT;
                    w_tmr_clr = 1'b1;
                end
            end
            WAIT: begin
                // done wins over a re-issued ld and over expiry in the same cycle.
                if (done) begin
                    w_capture = 1'b1;
                    w_next    = CHECK;
                end else if (ld) begin
                    w_spur    = 1'b1;
                    w_tmr_clr = 1'b1;
                end else if (r_timer == TMR_LAST) begin
                    w_tmo  = 1'b1;
                    w_next = IDLE;
                end
            end
            CHECK: begin
                w_spur = done;
                if (ld) begin
                    w_next    = WAIT;
                    w_tmr_clr = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_timer <= '0;
        end else if (w_tmr_clr) begin
            r_timer <= '0;
        end else if (r_state == WAIT) begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    // Compare copy is private to the CHECK cycle, so it needs no reset.
    always_ff @(posedge sys_clk) begin
        if (w_capture) begin
            r_cmp <= text_out;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_last <= '0;
        end else if (w_capture) begin
            r_last <= text_out;
        end
    end

    // CHECK lasts exactly one cycle, so the registered verdicts are single pulses.
    assign w_eq       = (r_cmp == EXPECTED);
    assign w_pass_inc = (r_state == CHECK) && w_eq;
    assign w_fail_inc = (r_state == CHECK) && !w_eq;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_match    <= 1'b0;
            r_mismatch <= 1'b0;
            r_err      <= 1'b0;
            r_led      <= 1'b0;
        end else begin
            r_match    <= w_pass_inc;
            r_mismatch <= w_fail_inc;
            if (w_spur || w_tmo || w_fail_inc) begin
                r_err <= 1'b1;
            end
            r_led <= (w_pass_cnt != '0) && !r_err;
        end
    end

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .inc       (w_pass_inc),
        .q         (w_pass_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .inc       (w_fail_inc),
        .q         (fail_cnt)
    );

    sat_counter #(.W(CNT_W)) u_timeout_cnt (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .inc       (w_tmo),
        .q         (timeout_cnt)
    );

    sat_counter #(.W(CNT_W)) u_spurious_cnt (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .inc       (w_spur),
        .q         (spurious_cnt)
    );

    assign busy        = (r_state != IDLE);
    assign match       = r_match;
    assign mismatch    = r_mismatch;
    assign err_sticky  = r_err;
    assign pass_cnt    = w_pass_cnt;
    assign last_result = r_last;
    assign status_led  = r_led;

endmodule

// File: tb/tb_aes_result_checker.sv
module tb_aes_result_checker;
    import aes_tb_pkg::*;

    localparam int TMO = 64;

    logic         sys_clk   = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic         ld        = 1'b0;
    logic         done      = 1'b0;
    logic [127:0] text_out  = '0;

    logic         busy, match, mismatch, err_sticky, status_led;
    logic [15:0]  pass_cnt, fail_cnt, timeout_cnt, spurious_cnt;
    logic [127:0] last_result;

    // Narrow-counter instance on the same stimulus exposes saturation quickly.
    logic         n_busy, n_match, n_mismatch, n_err, n_led;
    logic [1:0]   n_pass, n_fail, n_tmo, n_spur;
    logic [127:0] n_last;

    always #10 sys_clk = ~sys_clk;

    aes_result_checker #(.CNT_W(16)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .ld           (ld),
        .done         (done),
        .text_out     (text_out),
        .busy         (busy),
        .match        (match),
        .mismatch     (mismatch),
        .err_sticky   (err_sticky),
        .pass_cnt     (pass_cnt),
        .fail_cnt     (fail_cnt),
        .timeout_cnt  (timeout_cnt),
        .spurious_cnt (spurious_cnt),
        .last_result  (last_result),
        .status_led   (status_led)
    );

    aes_result_checker #(.CNT_W(2)) dut_n (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .ld           (ld),
        .done         (done),
        .text_out     (text_out),
        .busy         (n_busy),
        .match        (n_match),
        .mismatch     (n_mismatch),
        .err_sticky   (n_err),
        .pass_cnt     (n_pass),
        .fail_cnt     (n_fail),
        .timeout_cnt  (n_tmo),
        .spurious_cnt (n_spur),
        .last_result  (n_last),
        .status_led   (n_led)
    );

    int n_checks = 0;
    int n_pass_ok = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass_ok++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: event totals and the last accepted result.
    int           m_pass, m_fail, m_tmo, m_spur;
    logic [127:0] m_last;

    function automatic longint sat(input int v, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (longint'(v) > lim) ? lim : longint'(v);
    endfunction

    task automatic model_clear();
        m_pass = 0; m_fail = 0; m_tmo = 0; m_spur = 0; m_last = '0;
    endtask

    task automatic check_stats(input string tag);
        logic err_e, led_e;
        err_e = (m_fail + m_tmo + m_spur) != 0;
        led_e = (m_pass != 0) && !err_e;
        chk({tag, ".pass"},  pass_cnt,     128'(sat(m_pass, 16)));
        chk({tag, ".fail"},  fail_cnt,     128'(sat(m_fail, 16)));
        chk({tag, ".tmo"},   timeout_cnt,  128'(sat(m_tmo, 16)));
        chk({tag, ".spur"},  spurious_cnt, 128'(sat(m_spur, 16)));
        chk({tag, ".err"},   err_sticky,   128'(err_e));
        chk({tag, ".led"},   status_led,   128'(led_e));
        chk({tag, ".last"},  last_result,  m_last);
        chk({tag, ".busy"},  busy,         128'(0));
        chk({tag, ".npass"}, n_pass,       128'(sat(m_pass, 2)));
        chk({tag, ".nfail"}, n_fail,       128'(sat(m_fail, 2)));
        chk({tag, ".ntmo"},  n_tmo,        128'(sat(m_tmo, 2)));
        chk({tag, ".nspur"}, n_spur,       128'(sat(m_spur, 2)));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0; ld = 1'b0; done = 1'b0; text_out = '0;
        idle(2);
        sys_rst_n = 1'b1;
        model_clear();
    endtask

    // One request. k = cycles from the ld sample to the done sample; reissue
    // (if nonzero) re-sends ld that many cycles after the first. A result is
    // accepted when done lands within TMO cycles of the latest ld; otherwise
    // the request times out and the late done is spurious. send_ld=0 continues
    // from an ld already accepted during the previous CHECK cycle.
    task automatic txn(input bit send_ld, input int k, input int reissue,
                       input logic [127:0] txt, input bit ld_in_check, input string tag);
        bit accepted, good;
        if (send_ld) begin
            @(negedge sys_clk);
            ld = 1'b1;
        end
        for (int i = 1; i <= k; i++) begin
            if (send_ld || i > 1) @(negedge sys_clk);
            ld = (reissue != 0) && (i == reissue);
            if (i == k) begin
                done = 1'b1;
                text_out = txt;
            end
        end
        accepted = (k - reissue) <= TMO;
        good     = (txt == AES_KAT_CIPHER);
        @(negedge sys_clk);
        done = 1'b0;
        ld = ld_in_check && accepted;
        chk({tag, ".match_early"}, match, 128'(0));
        chk({tag, ".busy_chk"},    busy,  128'(accepted));
        @(negedge sys_clk);
        ld = 1'b0;
        chk({tag, ".match"},    match,    128'(accepted && good));
        chk({tag, ".mismatch"}, mismatch, 128'(accepted && !good));
        chk({tag, ".busy_after"}, busy,   128'(ld_in_check && accepted));
        if (reissue != 0) m_spur++;
        if (accepted) begin
            m_last = txt;
            if (good) m_pass++; else m_fail++;
        end else begin
            m_tmo++;
            m_spur++;
        end
    endtask

    task automatic spurious_done(input logic [127:0] txt);
        @(negedge sys_clk);
        done = 1'b1; text_out = txt;
        @(negedge sys_clk);
        done = 1'b0;
        m_spur++;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int typ, k, r;
        logic [127:0] t;

        // Reset state
        model_clear();
        idle(2);
        chk("rst.match",    match,    128'(0));
        chk("rst.mismatch", mismatch, 128'(0));
        check_stats("rst");
        sys_rst_n = 1'b1;
        idle(2);

        // Known-answer pass
        txn(1, 12, 0, AES_KAT_CIPHER, 0, "kat");
        idle(3);
        check_stats("kat");

        // Single-bit corrupted result
        do_reset();
        txn(1, 12, 0, AES_KAT_CIPHER ^ 128'h1, 0, "bad");
        idle(3);
        check_stats("bad");
        chk("bad.last_value", last_result, 128'h3ad77bb40d7a3660a89ecaf32466ef96);

        // Timeout, then a late correct done in IDLE
        do_reset();
        @(negedge sys_clk);
        ld = 1'b1;
        for (int i = 1; i <= TMO; i++) begin
            @(negedge sys_clk);
            ld = 1'b0;
        end
        chk("tmo.busy_last", busy, 128'(1));
        @(negedge sys_clk);
        chk("tmo.busy_gone", busy, 128'(0));
        m_tmo++;
        spurious_done(AES_KAT_CIPHER);
        idle(3);
        check_stats("tmo");

        // done on the final timer cycle, ld during CHECK, then finish that one
        do_reset();
        txn(1, TMO, 0, AES_KAT_CIPHER, 1, "edge");
        chk("edge.tmo_none", timeout_cnt, 128'(0));
        chk("edge.pass_one", pass_cnt,    128'(1));
        txn(0, 5, 0, AES_KAT_CIPHER, 0, "chain");
        idle(3);
        check_stats("edge");

        // Saturation: narrow instance must stop at 3
        do_reset();
        for (int i = 0; i < 5; i++) txn(1, 3 + i, 0, AES_KAT_CIPHER, 0, "sat");
        idle(3);
        check_stats("sat");

        // Asynchronous reset one cycle after done, while in CHECK
        do_reset();
        txn(1, 12, 0, AES_KAT_CIPHER, 0, "pre");
        @(negedge sys_clk);
        ld = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge sys_clk);
            ld = 1'b0;
            if (i == 12) begin
                done = 1'b1; text_out = AES_KAT_CIPHER;
            end
        end
        @(negedge sys_clk);
        done = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        model_clear();
        chk("arst.match", match, 128'(0));
        check_stats("arst");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            chk("arst.no_match", match, 128'(0));
        end

        // Randomized mix
        do_reset();
        for (int n = 0; n < 40; n++) begin
            typ = $urandom_range(0, 5);
            k = $urandom_range(1, TMO);
            case (typ)
                0: txn(1, k, 0, AES_KAT_CIPHER, 0, "rnd_good");
                1: begin
                    t = rand128();
                    if ($urandom_range(0, 1) == 1) t = AES_KAT_CIPHER ^ (128'h1 << $urandom_range(0, 127));
                    txn(1, k, 0, t, 0, "rnd_bad");
                end
                2: txn(1, $urandom_range(TMO + 1, TMO + 12), 0, AES_KAT_CIPHER, 0, "rnd_tmo");
                3: spurious_done(rand128());
                4: begin
                    r = $urandom_range(1, 20);
                    txn(1, r + $urandom_range(1, TMO), r, AES_KAT_CIPHER, 0, "rnd_reld");
                end
                default: begin
                    txn(1, k, 0, AES_KAT_CIPHER, 1, "rnd_chain");
                    txn(0, $urandom_range(1, TMO), 0,
                        ($urandom_range(0, 1) == 1) ? AES_KAT_CIPHER : rand128(), 0, "rnd_chain2");
                end
            endcase
            idle($urandom_range(3, 5));
            check_stats("rnd");
        end

        $display("%0d/%0d checks passed", n_pass_ok, n_checks);
        $finish;
    end

endmodule
